// File: rtl/class_mem_arb_rr.sv
// Round-robin arbiter that grants NCLIENT word-wide clients onto one
// single-port synchronous RAM line, with one transaction in flight at a time.
module class_mem_arb_rr #(
    parameter int NCLIENT = 4,
    parameter int AW      = 13,
    parameter int DW      = 128,
    parameter int WW      = 32,
    parameter int CAW     = 17,
    parameter int RD_LAT  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCLIENT-1:0]     req,
    input  logic [NCLIENT-1:0]     wr,
    input  logic [NCLIENT*CAW-1:0] addr,
    input  logic [NCLIENT*WW-1:0]  wdata,
    output logic [NCLIENT-1:0]     ack,
    output logic [WW-1:0]          rdata,
    output logic                   busy,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [DW/WW-1:0]       mem_wen,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic [DW-1:0]          mem_rdata,
    output logic [1:0]             dbg_state_o
);
    localparam int NL = DW / WW;
    localparam int LB = $clog2(DW / 8);
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int IW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
    localparam int CW = 3;

    // Handshake: a client holds req (with wr/addr/wdata stable) until it sees
    // a one-cycle ack; rdata is meaningful only in that ack cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  win_q, win_d;
    logic           wr_q, wr_d;
    logic [LW-1:0]  lane_q, lane_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]  rdata_q, rdata_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;

    logic [CAW-1:0] addr_a  [NCLIENT];
    logic [WW-1:0]  wdata_a [NCLIENT];
    logic           gnt_any;
    logic [IW-1:0]  gnt_id;
    logic [IW-1:0]  cand;
    logic [CAW-1:0] gnt_addr;
    logic [LW-1:0]  gnt_lane;
    logic [AW-1:0]  gnt_line;

    always_comb begin
        for (int i = 0; i < NCLIENT; i++) begin
            addr_a[i]  = addr[i*CAW +: CAW];
            wdata_a[i] = wdata[i*WW +: WW];
        end
    end

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int i = 0; i < NCLIENT; i++) begin
            cand = IW'((int'(ptr_q) + i) % NCLIENT);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // Byte-address decode: bits [1:0] dropped, lane below the line offset.
    always_comb begin
        gnt_addr = addr_a[gnt_id];
        gnt_lane = LW'((gnt_addr >> 2) % NL);
        gnt_line = AW'(gnt_addr >> LB);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        wr_d        = wr_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    win_d      = gnt_id;
                    wr_d       = wr[gnt_id];
                    lane_d     = gnt_lane;
                    mem_addr_d = gnt_line;
                    if (wr[gnt_id]) begin
                        mem_wdata_d = {NL{wdata_a[gnt_id]}};
                    end
                    ptr_d   = (gnt_id == IW'(NCLIENT - 1)) ? '0 : gnt_id + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = CW'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    rdata_d = mem_rdata[lane_q*WW +: WW];
                    state_d = ACK;
                end
            end
            ACK: begin
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            wr_q        <= 1'b0;
            lane_q      <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            wr_q        <= wr_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Memory strobes exist only in ISSUE; address and data simply hold.
    always_comb begin
        mem_en  = (state_q == ISSUE);
        mem_we  = mem_en & wr_q;
        mem_wen = '0;
        if (mem_we) begin
            mem_wen[lane_q] = 1'b1;
        end
        ack = '0;
        if (state_q == ACK) begin
            ack[win_q] = 1'b1;
        end
    end

    assign rdata       = rdata_q;
    assign busy        = (state_q != IDLE);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/class_mem_arb_rr.md
Name: class_mem_arb_rr

Overview:
Parametrised multi-client arbiter for classifier table memories (hash table, key/action RAMs). It replaces the single-client hash-table arbiter. It grants up to NCLIENT PIO/lookup requestors round-robin onto one single-port synchronous RAM. It supports 32-bit word-lane writes without read-modify-write, a configurable read latency, and single-cycle write completion.

Parameters:
NCLIENT, 4, number of requestors (1..8)
AW, 13, memory line address width
DW, 128, memory line width; must be a multiple of WW, power of two
WW, 32, client data word width
CAW, 17, client byte-address width; must be >= AW + log2(DW/8)
RD_LAT, 3, cycles from mem_en (read) to valid mem_rdata (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NCLIENT  per-client request; held until ack
wr  in  NCLIENT  per-client 1=write, 0=read; stable while req
addr  in  NCLIENT*CAW  per-client byte address, client i at [i*CAW +: CAW]
wdata  in  NCLIENT*WW  per-client write word
ack  out  NCLIENT  one-cycle completion pulse, one-hot or zero
rdata  out  WW  read word, valid only with ack of a read; else 0
busy  out  1  transaction in progress (state != IDLE)
mem_en  out  1  memory access strobe
mem_we  out  1  write strobe, qualified by mem_en
mem_wen  out  DW/WW  word-lane write enable
mem_addr  out  AW  line address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid RD_LAT cycles after read mem_en

Behaviour:
- The clock is clk. Reset rst is synchronous and active-high. On reset: ack=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_wen=0, mem_addr=0, mem_wdata=0, rr pointer=0, FSM=IDLE.
- Address decode: addr[1:0] ignored. Lane = addr[log2(DW/8)-1:2]. Line = addr[log2(DW/8)+AW-1 : log2(DW/8)]. Higher bits are ignored.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any req is set, pick a winner by round-robin starting at the pointer (lowest index at or above the pointer, wrapping). Latch winner id, wr, lane, line and wdata. Go to ISSUE. Pointer <= winner+1 mod NCLIENT.
- ISSUE: one cycle with mem_en=1 and mem_addr=line.
  - Write: mem_we=1; mem_wen one-hot at lane; mem_wdata = wdata replicated on every lane. Go to ACK.
  - Read: mem_we=0, mem_wen=0. Load latency counter with RD_LAT. Go to WAIT.
- mem_en, mem_we and mem_wen are 0 in every state except ISSUE. mem_addr and mem_wdata hold their last values.
- WAIT: counter decrements each cycle. When the counter reaches 1, capture mem_rdata[lane*WW +: WW] into rdata. Go to ACK.
- ACK: ack[winner]=1 for exactly one cycle; rdata holds the captured word for a read and is 0 for a write. Requests are not sampled in this state. Go to IDLE; rdata returns to 0.
- Latency, with req sampled in IDLE at cycle T: write ack at T+2; read ack at T+2+RD_LAT.
- Throughput: one transaction in flight. A client deasserts req in the cycle after ack. Back-to-back transactions from different clients start in the IDLE cycle after ACK, with no dead cycle beyond IDLE.
- Requests arriving during ISSUE, WAIT or ACK wait; nothing is dropped.
- A req that drops before ack: the latched transaction still completes and its ack is still issued.
- Simultaneous requests: served in pointer order. No client waits more than NCLIENT-1 grants.
- Reset mid-transaction: the in-flight read is discarded, no ack is issued, and the pointer returns to 0.
- NCLIENT=1 degenerates to a fixed grant; the pointer stays 0.

Test Plan:
- Single read: client 0 reads addr 0x00014, mem line 1 = 0xDDDD_CCCC_BBBB_AAAA_..., RD_LAT=3 -> mem_addr=1, ack[0] at T+5, rdata=word lane 1; all other cycles rdata=0.
- Single write: client 2 writes 0xCAFEF00D to addr 0x0002C -> at T+1 mem_en=1, mem_we=1, mem_addr=2, mem_wen=4'b1000, mem_wdata=4x0xCAFEF00D; ack[2] at T+2.
- Contention: clients 0, 1 and 3 assert together with pointer=0 -> grants in order 0,1,3. Then all four assert -> next grant is 0, then 1,2,3; each ack is one-hot.
- Fairness soak: all clients request continuously for 1000 transactions -> per-client grant counts differ by at most 1, and max wait is at most 3 grants.
- Reset in WAIT: assert rst for one cycle mid-read -> no ack, all outputs 0 in the next cycle, and the next request from client 3 is granted normally.
- Parameter sweep: DW=64, WW=32, AW=10, RD_LAT=1, NCLIENT=2 -> lane is addr[2], line is addr[12:3], read ack at T+3.
